// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch-to-decode instruction handshake bundle
interface fetch_unit_if #(
  parameter int N  = 16,
  parameter int AW = 10
);
  logic [N-1:0]  instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;

  modport master (output instr, output instr_pc, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_pc, input instr_valid, output instr_ready);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with one-entry skid, redirect flush and halt
// FETCH_PERF_EN adds fetch_cnt/bubble_cnt performance counters.
module fetch_unit #(
  parameter int            N        = 16,
  parameter int            AW       = 10,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [3:0]    HALT_OP  = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] PC,
  input  logic [N-1:0]  mem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  fetch_unit_if.master  dec,
  output logic          halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   bubble_cnt
`endif
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          req_valid_q, req_valid_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic [N-1:0]  instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          instr_valid_q, instr_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [N-1:0]  skid_instr_q, skid_instr_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;
  logic          halted_q, halted_d;

  logic xfer, halt_xfer, issue;

  assign xfer      = instr_valid_q && dec.instr_ready;
  assign halt_xfer = xfer && (instr_q[N-1:N-4] == HALT_OP);
  assign issue     = !skid_valid_q && !(req_valid_q && instr_valid_q && !dec.instr_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_pc_q      <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      halted_q      <= halted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_valid_d   = req_valid_q;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    halted_d      = halted_q;
    case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          // Redirect beats a simultaneous halt transfer; everything in flight is dropped.
          pc_d          = redirect_pc;
          req_valid_d   = 1'b0;
          skid_valid_d  = 1'b0;
          instr_valid_d = 1'b0;
        end else if (halt_xfer) begin
          state_d       = S_HALTED;
          halted_d      = 1'b1;
          req_valid_d   = 1'b0;
          skid_valid_d  = 1'b0;
          instr_valid_d = 1'b0;
        end else begin
          req_valid_d = issue;
          if (issue) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + {{(AW-1){1'b0}}, 1'b1};
          end
          if (xfer) instr_valid_d = 1'b0;
          if (xfer && skid_valid_q) begin
            instr_d       = skid_instr_q;
            instr_pc_d    = skid_pc_q;
            instr_valid_d = 1'b1;
            skid_valid_d  = 1'b0;
          end
          // A returning word never coexists with a full skid, so only two landing spots exist.
          if (req_valid_q) begin
            if (!instr_valid_q || xfer) begin
              instr_d       = mem_data;
              instr_pc_d    = req_pc_q;
              instr_valid_d = 1'b1;
            end else begin
              skid_instr_d = mem_data;
              skid_pc_d    = req_pc_q;
              skid_valid_d = 1'b1;
            end
          end
        end
      end
      default: begin
        req_valid_d   = 1'b0;
        instr_valid_d = 1'b0;
        skid_valid_d  = 1'b0;
      end
    endcase
  end

  assign PC              = pc_q;
  assign dec.instr       = instr_q;
  assign dec.instr_pc    = instr_pc_q;
  assign dec.instr_valid = instr_valid_q;
  assign halted          = halted_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (xfer && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (state_q == S_RUN && !instr_valid_q && bubble_cnt_q != 16'hFFFF)
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus randomized scoreboard run for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  PC;
  logic [15:0] mem_data;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt, bubble_cnt;
`endif

  logic [15:0] mem [1024];

  fetch_unit_if #(.N(16), .AW(10)) dec ();

  fetch_unit #(.N(16), .AW(10), .RESET_PC(10'd0), .HALT_OP(4'hF)) dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) mem_data <= mem[PC];

  typedef struct {
    logic        r, rdy, rv;
    logic [9:0]  rpc;
    logic        ev, cd;
    logic [15:0] ei;
    logic [9:0]  eip;
    logic        eh;
    logic [9:0]  epc;
  } vec_t;

  vec_t tv[35];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [9:0]  exp_pc, tgt, rpc_r, cp;
  logic [15:0] ci;
  logic        cv, rdy_r, rv_r;
  int          age, idle;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec.instr_ready = 1'b1;
    for (int a = 0; a < 1024; a++) mem[a] = 16'h0A00 + 16'(a);
    mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'h3003; mem[5] = 16'hF123;

    //        r  rdy rv rpc     ev cd ei        eip     eh epc
    tv[0]  = '{1, 1, 0, 10'h0,   0, 1, 16'h0000, 10'h0,   0, 10'h0};
    tv[1]  = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   0, 10'h1};
    tv[2]  = '{0, 1, 0, 10'h0,   1, 1, 16'h1001, 10'h0,   0, 10'h2};
    tv[3]  = '{0, 1, 0, 10'h0,   1, 1, 16'h2002, 10'h1,   0, 10'h3};
    tv[4]  = '{0, 1, 0, 10'h0,   1, 1, 16'h3003, 10'h2,   0, 10'h4};
    tv[5]  = '{0, 0, 0, 10'h0,   1, 1, 16'h3003, 10'h2,   0, 10'h4};
    tv[6]  = '{0, 0, 0, 10'h0,   1, 1, 16'h3003, 10'h2,   0, 10'h4};
    tv[7]  = '{0, 0, 0, 10'h0,   1, 1, 16'h3003, 10'h2,   0, 10'h4};
    tv[8]  = '{0, 1, 0, 10'h0,   1, 1, 16'h0A03, 10'h3,   0, 10'h4};
    tv[9]  = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   0, 10'h5};
    tv[10] = '{0, 1, 0, 10'h0,   1, 1, 16'h0A04, 10'h4,   0, 10'h6};
    tv[11] = '{0, 0, 0, 10'h0,   1, 1, 16'h0A04, 10'h4,   0, 10'h6};
    tv[12] = '{0, 0, 1, 10'h200, 0, 0, 16'h0000, 10'h0,   0, 10'h200};
    tv[13] = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   0, 10'h201};
    tv[14] = '{0, 1, 0, 10'h0,   1, 1, 16'h0C00, 10'h200, 0, 10'h202};
    tv[15] = '{0, 1, 1, 10'h3FE, 0, 0, 16'h0000, 10'h0,   0, 10'h3FE};
    tv[16] = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   0, 10'h3FF};
    tv[17] = '{0, 1, 0, 10'h0,   1, 1, 16'h0DFE, 10'h3FE, 0, 10'h0};
    tv[18] = '{0, 1, 0, 10'h0,   1, 1, 16'h0DFF, 10'h3FF, 0, 10'h1};
    tv[19] = '{0, 1, 0, 10'h0,   1, 1, 16'h1001, 10'h0,   0, 10'h2};
    tv[20] = '{0, 1, 1, 10'h5,   0, 0, 16'h0000, 10'h0,   0, 10'h5};
    tv[21] = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   0, 10'h6};
    tv[22] = '{0, 1, 0, 10'h0,   1, 1, 16'hF123, 10'h5,   0, 10'h7};
    tv[23] = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   1, 10'h7};
    tv[24] = '{0, 1, 1, 10'h100, 0, 0, 16'h0000, 10'h0,   1, 10'h7};
    tv[25] = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   1, 10'h7};
    tv[26] = '{1, 1, 0, 10'h0,   0, 1, 16'h0000, 10'h0,   0, 10'h0};
    tv[27] = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   0, 10'h1};
    tv[28] = '{0, 1, 0, 10'h0,   1, 1, 16'h1001, 10'h0,   0, 10'h2};
    tv[29] = '{0, 1, 1, 10'h5,   0, 0, 16'h0000, 10'h0,   0, 10'h5};
    tv[30] = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   0, 10'h6};
    tv[31] = '{0, 1, 0, 10'h0,   1, 1, 16'hF123, 10'h5,   0, 10'h7};
    tv[32] = '{0, 1, 1, 10'h10,  0, 0, 16'h0000, 10'h0,   0, 10'h10};
    tv[33] = '{0, 1, 0, 10'h0,   0, 0, 16'h0000, 10'h0,   0, 10'h11};
    tv[34] = '{0, 1, 0, 10'h0,   1, 1, 16'h0A10, 10'h10,  0, 10'h12};

    for (int i = 0; i < 35; i++) begin
      rst = tv[i].r; dec.instr_ready = tv[i].rdy;
      redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc;
      step();
      chk($sformatf("v%0d valid", i), 32'(dec.instr_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(tv[i].eh));
      chk($sformatf("v%0d PC", i), 32'(PC), 32'(tv[i].epc));
      if (tv[i].cd) begin
        chk($sformatf("v%0d instr", i), 32'(dec.instr), 32'(tv[i].ei));
        chk($sformatf("v%0d instr_pc", i), 32'(dec.instr_pc), 32'(tv[i].eip));
      end
    end

    // Randomized run against a program-order scoreboard; no halt opcodes in the image.
    rst = 1'b1; redirect_valid = 1'b0; dec.instr_ready = 1'b1;
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom) & 16'h7FFF;
    step(); step();
    rst = 1'b0;
    exp_pc = 10'd0; tgt = 10'd0; age = 100; idle = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy_r = ($urandom_range(3) != 0);
      rv_r  = (age >= 3) && ($urandom_range(24) == 0);
      rpc_r = 10'($urandom_range(1023));
      cv = dec.instr_valid; ci = dec.instr; cp = dec.instr_pc;
      dec.instr_ready = rdy_r; redirect_valid = rv_r; redirect_pc = rpc_r;
      step();
      if (cv && rdy_r) begin
        chk("rnd xfer_pc", 32'(cp), 32'(exp_pc));
        chk("rnd xfer_instr", 32'(ci), 32'(mem[exp_pc]));
        exp_pc = exp_pc + 10'd1;
      end
      if (rv_r) begin
        exp_pc = rpc_r; tgt = rpc_r; age = 0; idle = 0;
        chk("rnd redir_flush", 32'(dec.instr_valid), 32'd0);
        chk("rnd redir_PC", 32'(PC), 32'(rpc_r));
      end else begin
        age++;
        if (cv && !rdy_r) begin
          chk("rnd hold_valid", 32'(dec.instr_valid), 32'd1);
          chk("rnd hold_instr", 32'(dec.instr), 32'(ci));
          chk("rnd hold_pc", 32'(dec.instr_pc), 32'(cp));
        end
        if (age == 2) begin
          chk("rnd redir_latency_valid", 32'(dec.instr_valid), 32'd1);
          chk("rnd redir_latency_pc", 32'(dec.instr_pc), 32'(tgt));
        end
        idle = dec.instr_valid ? 0 : idle + 1;
        chk("rnd liveness", 32'(idle <= 3), 32'd1);
      end
      chk("rnd halted", 32'(halted), 32'd0);
    end

`ifdef FETCH_PERF_EN
    rst = 1'b1; redirect_valid = 1'b0; dec.instr_ready = 1'b1;
    step();
    chk("perf reset fetch", 32'(fetch_cnt), 32'd0);
    chk("perf reset bubble", 32'(bubble_cnt), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    redirect_valid = 1'b1; redirect_pc = 10'h40;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("perf fetch_cnt", 32'(fetch_cnt), 32'd4);
    chk("perf bubble_cnt", 32'(bubble_cnt), 32'd4);
    chk("perf redirect_target", 32'(dec.instr_pc), 32'h40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
